// File: rtl/synth_pkg.sv
// Shared types and default widths for the synth control blocks.
package synth_pkg;

    localparam int DIV_W   = 8;
    localparam int LEN_W   = 4;
    localparam int TEMPO_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [DIV_W-1:0] divide;
        logic [LEN_W-1:0] len;
    } step_t;

endpackage

// File: rtl/beat_timer.sv
// Tempo prescaler: counts clk cycles and pulses beat_o once every max(tempo,1) cycles.
module beat_timer #(
    parameter int TEMPO_W = synth_pkg::TEMPO_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic [TEMPO_W-1:0] tempo_i,
    output logic               beat_o
);

    logic [TEMPO_W-1:0] cnt_q, cnt_d;
    logic [TEMPO_W-1:0] limit;

    // >= rather than == so a tempo lowered below the running count wraps at once.
    always_comb begin
        limit  = (tempo_i == '0) ? '0 : tempo_i - TEMPO_W'(1);
        beat_o = !clr_i && (cnt_q >= limit);
        cnt_d  = cnt_q + TEMPO_W'(1);
        if (clr_i || beat_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Step sequencer: plays divide values from a small pattern memory into the clock divider,
// one step per max(len,1) beats, with a one-cycle LOAD gap between steps.
//
//   state | meaning
//   IDLE  | not playing; waits for start
//   LOAD  | one cycle; pattern entry for step_idx is presented by the read register
//   PLAY  | divide/gate driven from the entry; counts beats until the step ends
module note_sequencer #(
    parameter  int N       = synth_pkg::DIV_W,
    parameter  int DEPTH   = 16,
    parameter  int LEN_W   = synth_pkg::LEN_W,
    parameter  int TEMPO_W = synth_pkg::TEMPO_W,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en_i,
    input  logic [AW-1:0]      wr_addr_i,
    input  logic [N-1:0]       wr_divide_i,
    input  logic [LEN_W-1:0]   wr_len_i,
    input  logic [TEMPO_W-1:0] tempo_i,
    input  logic [AW-1:0]      last_step_i,
    input  logic               loop_en_i,
    input  logic               start_i,
    input  logic               stop_i,
    output logic [N-1:0]       divide_o,
    output logic               gate_o,
    output logic               busy_o,
    output logic [AW-1:0]      step_idx_o,
    output logic               done_o
);

    import synth_pkg::*;

    logic [N+LEN_W-1:0] mem [DEPTH];
    logic [N+LEN_W-1:0] rd_q;
    logic [N-1:0]       rd_divide;
    logic [LEN_W-1:0]   rd_len;

    seq_state_t         state_q, state_d;
    logic [AW-1:0]      step_idx_q, step_idx_d;
    logic [N-1:0]       divide_q, divide_d;
    logic [LEN_W-1:0]   beats_q, beats_d;
    logic               gate_q, gate_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               beat;

    assign rd_divide = rd_q[N+LEN_W-1:LEN_W];
    assign rd_len    = rd_q[LEN_W-1:0];

    beat_timer #(
        .TEMPO_W (TEMPO_W)
    ) u_beat_timer (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (state_q != PLAY),
        .tempo_i (tempo_i),
        .beat_o  (beat)
    );

    // Read is issued on the edge that enters LOAD so the entry is ready for PLAY entry;
    // a write to the same address during LOAD lands after the read (read-first).
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= {wr_divide_i, wr_len_i};
        end
        if (state_d == LOAD) begin
            rd_q <= mem[step_idx_d];
        end
    end

    always_comb begin
        state_d    = state_q;
        step_idx_d = step_idx_q;
        divide_d   = divide_q;
        beats_d    = beats_q;
        gate_d     = gate_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                gate_d = 1'b0;
                if (start_i && !stop_i) begin
                    step_idx_d = '0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                gate_d = 1'b0;
                if (stop_i) begin
                    state_d = IDLE;
                end else begin
                    state_d  = PLAY;
                    divide_d = rd_divide;
                    gate_d   = (rd_divide != '0);
                    beats_d  = (rd_len == '0) ? LEN_W'(1) : rd_len;
                end
            end
            PLAY: begin
                if (stop_i) begin
                    state_d = IDLE;
                    gate_d  = 1'b0;
                end else if (beat) begin
                    beats_d = beats_q - LEN_W'(1);
                    if (beats_q == LEN_W'(1)) begin
                        gate_d = 1'b0;
                        if (step_idx_q != last_step_i) begin
                            step_idx_d = step_idx_q + AW'(1);
                            state_d    = LOAD;
                        end else if (loop_en_i) begin
                            step_idx_d = '0;
                            state_d    = LOAD;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gate_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            step_idx_q <= '0;
            divide_q   <= '0;
            beats_q    <= '0;
            gate_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_idx_q <= step_idx_d;
            divide_q   <= divide_d;
            beats_q    <= beats_d;
            gate_q     <= gate_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign divide_o   = divide_q;
    assign gate_o     = gate_q;
    assign busy_o     = busy_q;
    assign step_idx_o = step_idx_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed self-checking bench for note_sequencer.
module tb_note_sequencer;

    localparam int N       = 8;
    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int LEN_W   = 4;
    localparam int TEMPO_W = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               wr_en = 1'b0;
    logic [AW-1:0]      wr_addr = '0;
    logic [N-1:0]       wr_divide = '0;
    logic [LEN_W-1:0]   wr_len = '0;
    logic [TEMPO_W-1:0] tempo = '0;
    logic [AW-1:0]      last_step = '0;
    logic               loop_en = 1'b0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic [N-1:0]       divide;
    logic               gate;
    logic               busy;
    logic [AW-1:0]      step_idx;
    logic               done;

    int n_checks = 0;
    int n_fail   = 0;

    note_sequencer #(
        .N       (N),
        .DEPTH   (DEPTH),
        .LEN_W   (LEN_W),
        .TEMPO_W (TEMPO_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_divide_i (wr_divide),
        .wr_len_i    (wr_len),
        .tempo_i     (tempo),
        .last_step_i (last_step),
        .loop_en_i   (loop_en),
        .start_i     (start),
        .stop_i      (stop),
        .divide_o    (divide),
        .gate_o      (gate),
        .busy_o      (busy),
        .step_idx_o  (step_idx),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_step(input int a, input int d, input int l);
        wr_en     = 1'b1;
        wr_addr   = AW'(a);
        wr_divide = N'(d);
        wr_len    = LEN_W'(l);
        tick();
        wr_en     = 1'b0;
    endtask

    task automatic load_basic();
        write_step(0, 10, 2);
        write_step(1, 0, 1);
        write_step(2, 40, 1);
    endtask

    // Leaves the bench at the sample point of the LOAD cycle (c0).
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({busy, gate, done, step_idx, divide} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_values: got busy=%b gate=%b done=%b step=%0d div=%0d, expected all 0",
                     busy, gate, done, step_idx, divide);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic eb, eg, ed;
        logic [AW-1:0] es;
        logic [N-1:0]  ev;
        load_basic();
        tempo     = 16'd3;
        last_step = 4'd2;
        loop_en   = 1'b0;
        pulse_start();
        for (int c = 0; c <= 16; c++) begin
            eb = (c <= 14);
            eg = (c >= 1 && c <= 6) || (c >= 12 && c <= 14);
            ed = (c == 15);
            es = (c <= 6) ? 4'd0 : (c <= 10) ? 4'd1 : 4'd2;
            ev = (c == 0) ? 8'd0 : (c <= 7) ? 8'd10 : (c <= 11) ? 8'd0 : 8'd40;
            n_checks++;
            if ({busy, gate, done, step_idx, divide} !== {eb, eg, ed, es, ev}) begin
                n_fail++;
                $display("FAIL basic c%0d: got busy=%b gate=%b done=%b step=%0d div=%0d, expected %b %b %b %0d %0d",
                         c, busy, gate, done, step_idx, divide, eb, eg, ed, es, ev);
            end
            tick();
        end
    endtask

    task automatic test_loop_and_stop();
        int p;
        logic eg;
        logic [AW-1:0] es;
        logic [N-1:0]  ev;
        loop_en = 1'b1;
        pulse_start();
        for (int c = 0; c <= 30; c++) begin
            p  = c % 15;
            eg = (p >= 1 && p <= 6) || (p >= 12 && p <= 14);
            es = (p <= 6) ? 4'd0 : (p <= 10) ? 4'd1 : 4'd2;
            ev = (p == 0) ? 8'd40 : (p <= 7) ? 8'd10 : (p <= 11) ? 8'd0 : 8'd40;
            n_checks++;
            if ({busy, gate, done, step_idx, divide} !== {1'b1, eg, 1'b0, es, ev}) begin
                n_fail++;
                $display("FAIL loop c%0d: got busy=%b gate=%b done=%b step=%0d div=%0d, expected 1 %b 0 %0d %0d",
                         c, busy, gate, done, step_idx, divide, eg, es, ev);
            end
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if ({busy, gate, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL stop_mid_play: got busy=%b gate=%b done=%b, expected 0 0 0", busy, gate, done);
        end
        tick();
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL stop_stays_idle: got busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_stop_start_idle();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        n_checks++;
        if ({busy, gate, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL stop_start_idle: got busy=%b gate=%b done=%b, expected 0 0 0", busy, gate, done);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_start_no_restart: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_zero_values();
        write_step(0, 7, 0);
        tempo     = 16'd0;
        last_step = 4'd0;
        loop_en   = 1'b0;
        pulse_start();
        n_checks++;
        if ({busy, gate, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL zero_load: got busy=%b gate=%b done=%b, expected 1 0 0", busy, gate, done);
        end
        tick();
        n_checks++;
        if ({busy, gate, done, divide} !== {3'b110, 8'd7}) begin
            n_fail++;
            $display("FAIL zero_play: got busy=%b gate=%b done=%b div=%0d, expected 1 1 0 7",
                     busy, gate, done, divide);
        end
        tick();
        n_checks++;
        if ({busy, gate, done, divide} !== {3'b001, 8'd7}) begin
            n_fail++;
            $display("FAIL zero_done: got busy=%b gate=%b done=%b div=%0d, expected 0 0 1 7",
                     busy, gate, done, divide);
        end
        tick();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done_one_cycle: got done=%b, expected 0", done);
        end
    endtask

    task automatic test_tempo_lower();
        write_step(0, 9, 1);
        tempo     = 16'd10;
        last_step = 4'd0;
        loop_en   = 1'b0;
        pulse_start();
        for (int c = 1; c <= 6; c++) begin
            tick();
            n_checks++;
            if ({busy, gate, done} !== 3'b110) begin
                n_fail++;
                $display("FAIL tempo_play c%0d: got busy=%b gate=%b done=%b, expected 1 1 0",
                         c, busy, gate, done);
            end
        end
        tempo = 16'd2;
        tick();
        n_checks++;
        if ({busy, done} !== 2'b01) begin
            n_fail++;
            $display("FAIL tempo_lowered_wrap: got busy=%b done=%b, expected 0 1", busy, done);
        end
        tick();
    endtask

    task automatic test_load_write();
        load_basic();
        tempo     = 16'd3;
        last_step = 4'd2;
        loop_en   = 1'b1;
        pulse_start();
        wr_en     = 1'b1;
        wr_addr   = 4'd0;
        wr_divide = 8'd20;
        wr_len    = 4'd2;
        tick();
        wr_en     = 1'b0;
        n_checks++;
        if ({gate, divide} !== {1'b1, 8'd10}) begin
            n_fail++;
            $display("FAIL load_write_old: got gate=%b div=%0d, expected 1 10", gate, divide);
        end
        for (int i = 0; i < 15; i++) tick();
        n_checks++;
        if ({gate, step_idx, divide} !== {1'b1, 4'd0, 8'd20}) begin
            n_fail++;
            $display("FAIL load_write_new: got gate=%b step=%0d div=%0d, expected 1 0 20",
                     gate, step_idx, divide);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        load_basic();
        tempo     = 16'd3;
        last_step = 4'd2;
        loop_en   = 1'b0;
        pulse_start();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({busy, gate, done, step_idx, divide} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b gate=%b done=%b step=%0d div=%0d, expected all 0",
                     busy, gate, done, step_idx, divide);
        end
        rst = 1'b0;
        pulse_start();
        n_checks++;
        if ({busy, gate, step_idx, divide} !== {2'b10, 4'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_restart_load: got busy=%b gate=%b step=%0d div=%0d, expected 1 0 0 0",
                     busy, gate, step_idx, divide);
        end
        tick();
        n_checks++;
        if ({gate, step_idx, divide} !== {1'b1, 4'd0, 8'd10}) begin
            n_fail++;
            $display("FAIL reset_restart_step0: got gate=%b step=%0d div=%0d, expected 1 0 10",
                     gate, step_idx, divide);
        end
        for (int i = 0; i < 7; i++) tick();
        n_checks++;
        if ({busy, gate, step_idx, divide} !== {2'b10, 4'd1, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_restart_step1: got busy=%b gate=%b step=%0d div=%0d, expected 1 0 1 0",
                     busy, gate, step_idx, divide);
        end
        for (int i = 0; i < 7; i++) tick();
        n_checks++;
        if ({busy, done, divide} !== {2'b01, 8'd40}) begin
            n_fail++;
            $display("FAIL reset_restart_done: got busy=%b done=%b div=%0d, expected 0 1 40",
                     busy, done, divide);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_loop_and_stop();
        test_stop_start_idle();
        test_zero_values();
        test_tempo_lower();
        test_load_write();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
